axi_dma_desc_credit_ctrl: RTL and testbench
===========================================

Name: axi_dma_desc_credit_ctrl

Overview:
Per-port outstanding-descriptor governor placed between PORTS descriptor sources and the descriptor mux feeding one AXI DMA core. It passes descriptors through with zero latency while capping in-flight descriptors per port. Completions arrive on the per-port status valid and error outputs of the descriptor mux. Gives software-visible enable, runtime limit, occupancy, idle and error reporting per port so the shared DMA engine cannot be monopolised by one requester.

Parameters:
PORTS, 2, number of requester ports
AXI_ADDR_WIDTH, 16, descriptor address width
LEN_WIDTH, 20, descriptor length width
TAG_WIDTH, 8, descriptor tag width (passed through untouched)
MAX_OUTSTANDING, 16, hard ceiling on in-flight descriptors per port (>=1)
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), counter/limit field width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
s_axis_desc_addr  input  PORTS*AXI_ADDR_WIDTH  descriptor address from sources
s_axis_desc_len  input  PORTS*LEN_WIDTH  descriptor length
s_axis_desc_tag  input  PORTS*TAG_WIDTH  descriptor tag
s_axis_desc_valid  input  PORTS  source valid
s_axis_desc_ready  output  PORTS  source ready
m_axis_desc_addr  output  PORTS*AXI_ADDR_WIDTH  to mux, equals s_axis_desc_addr
m_axis_desc_len  output  PORTS*LEN_WIDTH  to mux, equals s_axis_desc_len
m_axis_desc_tag  output  PORTS*TAG_WIDTH  to mux, equals s_axis_desc_tag
m_axis_desc_valid  output  PORTS  gated valid to mux
m_axis_desc_ready  input  PORTS  mux ready
s_axis_desc_status_valid  input  PORTS  per-port completion pulse from mux
s_axis_desc_status_error  input  PORTS*4  per-port completion error code
enable  input  PORTS  per-port issue enable
limit  input  PORTS*CNT_WIDTH  per-port runtime outstanding limit
clear_error  input  PORTS  clears error_sticky
outstanding  output  PORTS*CNT_WIDTH  current in-flight count
port_idle  output  PORTS  count==0 and no valid presented
error_sticky  output  PORTS  latched nonzero completion error
underflow  output  PORTS  one-cycle pulse: completion with count==0

Behaviour:
- Clock/reset: single clock clk; rst synchronous active-high.
- Reset: outstanding=0, hold=0, error_sticky=0, underflow=0. m_axis_desc_valid and s_axis_desc_ready forced 0 while rst high. port_idle=1 after reset.
- Datapath: addr/len/tag combinational pass-through, zero latency. No buffering.
- Per port i: eff_limit = min(limit_i, MAX_OUTSTANDING). credit_ok = outstanding_i < eff_limit. limit_i=0 blocks the port.
- allow_i = hold_i | (enable_i & credit_ok).
- m_axis_desc_valid_i = s_valid_i & allow_i; s_axis_desc_ready_i = m_ready_i & allow_i.
- hold register (AXI valid stability): set when m_valid_i & !m_ready_i; cleared on handshake. While hold_i=1, deasserting enable or lowering limit does not drop an already-presented valid. New gating applies from the next descriptor.
- issue_i = m_valid_i & m_ready_i; comp_i = s_axis_desc_status_valid_i.
- Counter next state:
  - issue only: +1.
  - comp only with count>0: -1.
  - issue and comp together with count>0: unchanged.
  - comp with count==0: decrement suppressed; underflow_i pulses next cycle for one cycle; a simultaneous issue still yields count=1.
- Counter never exceeds MAX_OUTSTANDING, guaranteed by credit gating. Updated count is visible the cycle after the event.
- error_sticky_i: set when comp_i & error_i!=0. Cleared by clear_error_i. Set wins over a simultaneous clear.
- port_idle_i = (outstanding_i==0) & !m_axis_desc_valid_i, combinational from registered count.
- Ports are fully independent; no cross-port arbitration. The downstream mux arbitrates.

Test Plan:
- MAX_OUTSTANDING=16, limit_0=2, enable_0=1, m_ready=1, continuous valid on port 0, no completions -> exactly 2 handshakes, then s_ready_0=0, outstanding_0=2. One status pulse -> third handshake the following cycle, outstanding_0 stays 2.
- limit_1=20 (>MAX) -> port 1 caps at 16 outstanding, never 17.
- Port 0 valid held with m_ready_0=0; deassert enable_0 mid-stall -> m_valid_0 stays 1 until m_ready_0, handshake occurs, count+1, then valid gated to 0.
- Issue and completion in the same cycle at count=3 -> count stays 3. Completion at count=0 with no issue -> underflow pulses once, count stays 0. Completion at count=0 with an issue -> count 1, underflow pulse.
- Status error=4'h3 on port 1 -> error_sticky_1=1 next cycle. clear_error_1 alone -> 0. Error and clear together -> remains 1.
- Assert rst for one cycle with count=5, hold=1 -> next cycle outstanding=0, m_valid=0, error_sticky=0, port_idle=1 once valid is low.

Source files
------------

// File: rtl/axi_dma_desc_credit_ctrl_if.sv
// Descriptor stream bundle (one lane per port) between sources, governor and mux.
interface axi_dma_desc_credit_ctrl_if #(
   parameter int PORTS          = 2,
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int LEN_WIDTH      = 20,
   parameter int TAG_WIDTH      = 8
);
   logic [PORTS*AXI_ADDR_WIDTH-1:0] addr;
   logic [PORTS*LEN_WIDTH-1:0]      len;
   logic [PORTS*TAG_WIDTH-1:0]      tag;
   logic [PORTS-1:0]                valid;
   logic [PORTS-1:0]                ready;

   modport master (output addr, output len, output tag, output valid, input ready);
   modport slave  (input addr, input len, input tag, input valid, output ready);
endinterface

// File: rtl/axi_dma_desc_credit_ctrl.sv
// Per-port outstanding-descriptor governor: zero-latency pass-through with credit-gated
// valid/ready, completion accounting, sticky error and underflow reporting.
module axi_dma_desc_credit_ctrl #(
   parameter int PORTS           = 2,
   parameter int AXI_ADDR_WIDTH  = 16,
   parameter int LEN_WIDTH       = 20,
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   axi_dma_desc_credit_ctrl_if.slave  s_axis_desc,
   axi_dma_desc_credit_ctrl_if.master m_axis_desc,
   input  logic [PORTS-1:0]           s_axis_desc_status_valid,
   input  logic [PORTS*4-1:0]         s_axis_desc_status_error,
   input  logic [PORTS-1:0]           enable,
   input  logic [PORTS*CNT_WIDTH-1:0] limit,
   input  logic [PORTS-1:0]           clear_error,
   output logic [PORTS*CNT_WIDTH-1:0] outstanding,
   output logic [PORTS-1:0]           port_idle,
   output logic [PORTS-1:0]           error_sticky,
   output logic [PORTS-1:0]           underflow
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

   logic [CNT_WIDTH-1:0] cnt_q     [PORTS];
   logic [CNT_WIDTH-1:0] cnt_d     [PORTS];
   logic [CNT_WIDTH-1:0] eff_limit [PORTS];
   logic [PORTS-1:0]     hold_q;
   logic [PORTS-1:0]     allow;
   logic [PORTS-1:0]     m_valid;
   logic [PORTS-1:0]     issue;
   logic [PORTS-1:0]     comp;
   logic [PORTS-1:0]     err_seen;

   assign m_axis_desc.addr  = s_axis_desc.addr;
   assign m_axis_desc.len   = s_axis_desc.len;
   assign m_axis_desc.tag   = s_axis_desc.tag;
   assign m_axis_desc.valid = m_valid;

   always_comb begin
      allow       = '0;
      m_valid     = '0;
      issue       = '0;
      comp        = '0;
      err_seen    = '0;
      port_idle   = '0;
      outstanding = '0;
      s_axis_desc.ready = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         eff_limit[i] = (limit[i*CNT_WIDTH +: CNT_WIDTH] > MAX_CNT) ? MAX_CNT
                                                                   : limit[i*CNT_WIDTH +: CNT_WIDTH];
         // hold keeps an already-presented descriptor valid regardless of enable/limit changes
         allow[i]   = hold_q[i] | (enable[i] & (cnt_q[i] < eff_limit[i]));
         m_valid[i] = s_axis_desc.valid[i] & allow[i] & ~rst;
         s_axis_desc.ready[i] = m_axis_desc.ready[i] & allow[i] & ~rst;
         issue[i]    = m_valid[i] & m_axis_desc.ready[i];
         comp[i]     = s_axis_desc_status_valid[i];
         err_seen[i] = comp[i] & (s_axis_desc_status_error[i*4 +: 4] != 4'h0);
         port_idle[i] = (cnt_q[i] == '0) & ~m_valid[i];
         outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         unique case ({issue[i], comp[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
            2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            2'b11:   if (cnt_q[i] == '0) cnt_d[i] = CNT_WIDTH'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= '0;
         error_sticky <= '0;
         underflow    <= '0;
         for (int unsigned i = 0; i < PORTS; i++) cnt_q[i] <= '0;
      end else begin
         hold_q    <= m_valid & ~m_axis_desc.ready;
         underflow <= '0;
         for (int unsigned i = 0; i < PORTS; i++) begin
            cnt_q[i]     <= cnt_d[i];
            underflow[i] <= comp[i] & (cnt_q[i] == '0);
            if (err_seen[i])         error_sticky[i] <= 1'b1;
            else if (clear_error[i]) error_sticky[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_dma_desc_credit_ctrl.sv
// Randomized + directed bench for axi_dma_desc_credit_ctrl against a per-port behavioural model.
module tb_axi_dma_desc_credit_ctrl;
   localparam int P    = 2;
   localparam int AW   = 16;
   localparam int LW   = 20;
   localparam int TW   = 8;
   localparam int MAXO = 16;
   localparam int CW   = 5;

   logic clk = 1'b0;
   logic rst;
   logic [P-1:0]    status_valid;
   logic [P*4-1:0]  status_error;
   logic [P-1:0]    enable;
   logic [P*CW-1:0] limit;
   logic [P-1:0]    clear_error;
   logic [P*CW-1:0] outstanding;
   logic [P-1:0]    port_idle;
   logic [P-1:0]    error_sticky;
   logic [P-1:0]    underflow;

   axi_dma_desc_credit_ctrl_if #(.PORTS(P), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) s_if ();
   axi_dma_desc_credit_ctrl_if #(.PORTS(P), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) m_if ();

   axi_dma_desc_credit_ctrl #(
      .PORTS(P), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
      .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_desc(s_if), .m_axis_desc(m_if),
      .s_axis_desc_status_valid(status_valid),
      .s_axis_desc_status_error(status_error),
      .enable(enable), .limit(limit), .clear_error(clear_error),
      .outstanding(outstanding), .port_idle(port_idle),
      .error_sticky(error_sticky), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // model state: in-flight count, presented-but-unaccepted flag, sticky error, pending underflow
   int cnt_m  [P];
   bit pend_m [P];
   bit err_m  [P];
   bit uf_m   [P];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lim_of(input int p);
      int l;
      l = int'(limit[p*CW +: CW]);
      return (l > MAXO) ? MAXO : l;
   endfunction

   function automatic bit exp_mvalid(input int p);
      bit open;
      open = pend_m[p] || (enable[p] && (cnt_m[p] < lim_of(p)));
      return !rst && s_if.valid[p] && open;
   endfunction

   function automatic bit exp_sready(input int p);
      bit open;
      open = pend_m[p] || (enable[p] && (cnt_m[p] < lim_of(p)));
      return !rst && m_if.ready[p] && open;
   endfunction

   task automatic check_all();
      chk("addr_pass", 64'(m_if.addr), 64'(s_if.addr));
      chk("len_pass",  64'(m_if.len),  64'(s_if.len));
      chk("tag_pass",  64'(m_if.tag),  64'(s_if.tag));
      for (int p = 0; p < P; p++) begin
         chk($sformatf("m_valid[%0d]", p), 64'(m_if.valid[p]), 64'(exp_mvalid(p)));
         chk($sformatf("s_ready[%0d]", p), 64'(s_if.ready[p]), 64'(exp_sready(p)));
         chk($sformatf("outstanding[%0d]", p), 64'(outstanding[p*CW +: CW]), 64'(cnt_m[p]));
         chk($sformatf("port_idle[%0d]", p), 64'(port_idle[p]), 64'(cnt_m[p] == 0 && !exp_mvalid(p)));
         chk($sformatf("error_sticky[%0d]", p), 64'(error_sticky[p]), 64'(err_m[p]));
         chk($sformatf("underflow[%0d]", p), 64'(underflow[p]), 64'(uf_m[p]));
      end
   endtask

   task automatic update_model();
      bit iss, cmp, mv;
      for (int p = 0; p < P; p++) begin
         mv  = exp_mvalid(p);
         iss = mv && m_if.ready[p];
         cmp = status_valid[p];
         if (rst) begin
            cnt_m[p] = 0; pend_m[p] = 0; err_m[p] = 0; uf_m[p] = 0;
         end else begin
            uf_m[p] = cmp && (cnt_m[p] == 0);
            cnt_m[p] = cnt_m[p] + (iss ? 1 : 0) - ((cmp && cnt_m[p] > 0) ? 1 : 0);
            pend_m[p] = mv && !m_if.ready[p];
            if (cmp && status_error[p*4 +: 4] != 4'h0) err_m[p] = 1;
            else if (clear_error[p]) err_m[p] = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1 check_all();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic zero_inputs();
      status_valid = '0; status_error = '0; enable = '0; limit = '0; clear_error = '0;
      s_if.valid = '0; m_if.ready = '0;
   endtask

   task automatic randomize_inputs();
      rst = ($urandom_range(0, 199) == 0);
      s_if.addr = AW'($urandom);
      s_if.len  = LW'($urandom);
      s_if.tag  = TW'($urandom);
      for (int p = 0; p < P; p++) begin
         s_if.valid[p]   = ($urandom_range(0, 3) != 0);
         m_if.ready[p]   = ($urandom_range(0, 2) != 0);
         enable[p]       = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) limit[p*CW +: CW] = CW'($urandom_range(0, 20));
         status_valid[p] = ($urandom_range(0, 9) < 3);
         status_error[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         clear_error[p]  = ($urandom_range(0, 15) == 0);
      end
   endtask

   initial begin
      for (int p = 0; p < P; p++) begin cnt_m[p] = 0; pend_m[p] = 0; err_m[p] = 0; uf_m[p] = 0; end
      zero_inputs();
      s_if.addr = 16'h1234; s_if.len = 20'h00abc; s_if.tag = 8'h5a;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("lit_reset_idle", 64'(port_idle), 64'(2'b11));
      chk("lit_reset_out",  64'(outstanding), 64'h0);

      // credit limit of 2 on port 0
      limit[0 +: CW] = 5'd2; enable[0] = 1; m_if.ready[0] = 1; s_if.valid[0] = 1;
      tick(); tick(); tick();
      chk("lit_lim2_out", 64'(outstanding[0 +: CW]), 64'd2);
      chk("lit_lim2_rdy", 64'(s_if.ready[0]), 64'd0);
      status_valid[0] = 1; tick();
      status_valid[0] = 0; tick();
      chk("lit_lim2_refill", 64'(outstanding[0 +: CW]), 64'd2);
      s_if.valid[0] = 0;

      // limit above ceiling on port 1
      limit[CW +: CW] = 5'd20; enable[1] = 1; m_if.ready[1] = 1; s_if.valid[1] = 1;
      for (int k = 0; k < 20; k++) tick();
      chk("lit_cap16", 64'(outstanding[CW +: CW]), 64'd16);
      s_if.valid[1] = 0;

      // valid must survive enable drop during a stall
      limit[0 +: CW] = 5'd16; m_if.ready[0] = 0; s_if.valid[0] = 1; enable[0] = 1;
      tick();
      enable[0] = 0; tick();
      chk("lit_hold_valid", 64'(m_if.valid[0]), 64'd1);
      m_if.ready[0] = 1; tick();
      chk("lit_hold_cnt", 64'(outstanding[0 +: CW]), 64'd3);
      chk("lit_hold_gated", 64'(m_if.valid[0]), 64'd0);

      // simultaneous issue and completion
      enable[0] = 1; status_valid[0] = 1; tick();
      enable[0] = 0; status_valid[0] = 0;
      chk("lit_iss_comp", 64'(outstanding[0 +: CW]), 64'd3);

      // drain and underflow
      status_valid[0] = 1; tick(); tick(); tick(); tick();
      chk("lit_uf_pulse", 64'(underflow[0]), 64'd1);
      chk("lit_uf_cnt", 64'(outstanding[0 +: CW]), 64'd0);
      status_valid[0] = 0; tick();
      chk("lit_uf_clear", 64'(underflow[0]), 64'd0);
      enable[0] = 1; status_valid[0] = 1; tick();
      chk("lit_uf_iss_cnt", 64'(outstanding[0 +: CW]), 64'd1);
      chk("lit_uf_iss_pulse", 64'(underflow[0]), 64'd1);
      enable[0] = 0; status_valid[0] = 0; s_if.valid[0] = 0;

      // sticky error on port 1
      status_valid[1] = 1; status_error[4 +: 4] = 4'h3; tick();
      chk("lit_err_set", 64'(error_sticky[1]), 64'd1);
      status_valid[1] = 0; status_error = '0; clear_error[1] = 1; tick();
      chk("lit_err_clr", 64'(error_sticky[1]), 64'd0);
      status_valid[1] = 1; status_error[4 +: 4] = 4'h3; tick();
      chk("lit_err_wins", 64'(error_sticky[1]), 64'd1);
      zero_inputs();

      // reset with a stalled descriptor on port 0
      limit[0 +: CW] = 5'd8; enable[0] = 1; s_if.valid[0] = 1; m_if.ready[0] = 0;
      tick();
      rst = 1; tick();
      rst = 0; s_if.valid[0] = 0;
      #1;
      chk("lit_rst_out", 64'(outstanding), 64'h0);
      chk("lit_rst_valid", 64'(m_if.valid), 64'h0);
      chk("lit_rst_err", 64'(error_sticky), 64'h0);
      chk("lit_rst_idle", 64'(port_idle), 64'(2'b11));

      for (int k = 0; k < 3000; k++) begin
         randomize_inputs();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
